// File: rtl/kgprisc_pkg.sv
// KGPRISC shared decode definitions: opcode values, decode-stage FSM
// encoding and the packed control bundle produced by the opcode lookup.
package kgprisc_pkg;

  localparam int OPC_W_P = 6;

  localparam logic [OPC_W_P-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W_P-1:0] OP_ADDI  = 6'h01;
  localparam logic [OPC_W_P-1:0] OP_LW    = 6'h02;
  localparam logic [OPC_W_P-1:0] OP_SW    = 6'h03;
  localparam logic [OPC_W_P-1:0] OP_BR    = 6'h04;
  localparam logic [OPC_W_P-1:0] OP_CALL  = 6'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic ra_reg_write;
    logic illegal;
  } ctrl_t;

  // True for every opcode the core implements.
  function automatic logic is_legal_op(input logic [OPC_W_P-1:0] op);
    return op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BR, OP_CALL};
  endfunction

endpackage

// File: rtl/ctrl_lut.sv
// Combinational opcode/funct to control-bundle lookup for the decode stage.
module ctrl_lut
  import kgprisc_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 4
) (
  input  logic [OPC_W-1:0]   opcode,
  input  logic [ALUOP_W-1:0] funct,
  output ctrl_t              ctrl,
  output logic [ALUOP_W-1:0] alu_op
);

  // Decode table; anything not listed leaves every control low and flags illegal.
  always_comb begin
    ctrl   = '0;
    alu_op = '0;
    case (opcode)
      OPC_W'(OP_RTYPE): begin
        ctrl.reg_write = 1'b1;
        alu_op         = funct;
      end
      OPC_W'(OP_ADDI): begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_W'(OP_LW): begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OPC_W'(OP_SW): begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OPC_W'(OP_BR): begin
        ctrl.branch = 1'b1;
      end
      OPC_W'(OP_CALL): begin
        ctrl.branch       = 1'b1;
        ctrl.ra_reg_write = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// KGPRISC registered instruction-decode stage (fetch -> execute).
// Valid/ready on both sides, start gating, flush, halt on illegal opcode.
// Optional build macro DECODE_SKID_EN: 2-entry skid buffer ahead of the
// output register with a registered in_ready.
module instr_decode_stage
  import kgprisc_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 6,
  parameter int REG_AW  = 5,
  parameter int IMM_W   = 16,
  parameter int ALUOP_W = 4,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               branch,
  output logic               mem_read,
  output logic               mem_to_reg,
  output logic               mem_write,
  output logic               alu_src,
  output logic               reg_write,
  output logic               ra_reg_write,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [REG_AW-1:0]  rs,
  output logic [REG_AW-1:0]  rt,
  output logic [REG_AW-1:0]  rd,
  output logic [DATA_W-1:0]  imm_ext,
  output logic               illegal,
  output logic               halted
);

  localparam int RS_HI = INSTR_W - OPC_W - 1;
  localparam int RT_HI = RS_HI - REG_AW;
  localparam int RD_HI = RT_HI - REG_AW;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] f);
    logic signed [IMM_W-1:0] s;
    s = signed'(f);
    return DATA_W'(s);
  endfunction

  state_t state, state_nxt;

  logic               accept;
  logic               out_adv;
  logic               load_out;
  logic               in_legal;
  logic [INSTR_W-1:0] src_instr;
  ctrl_t              dec_ctrl;
  logic [ALUOP_W-1:0] dec_alu_op;

  logic                      vld_p1;
  ctrl_t                     ctrl_p1;
  logic [ALUOP_W-1:0]        alu_op_p1;
  logic [REG_AW-1:0]         rs_p1, rt_p1, rd_p1;
  logic signed [DATA_W-1:0]  imm_p1;

  assign accept   = in_valid && in_ready;
  assign out_adv  = !vld_p1 || out_ready;
  assign in_legal = is_legal_op(OPC_W_P'(in_instr[INSTR_W-1 -: OPC_W]));

`ifdef DECODE_SKID_EN
  logic [INSTR_W-1:0] skid_q [2];
  logic               head_q;
  logic [1:0]         cnt_q, cnt_nxt;
  logic               in_ready_q;
  logic               push, pop;

  // Oldest buffered word goes out first; an empty buffer lets the input bypass.
  assign pop       = out_adv && (cnt_q != 2'd0);
  assign push      = accept && !(out_adv && (cnt_q == 2'd0));
  assign load_out  = out_adv && ((cnt_q != 2'd0) || accept);
  assign src_instr = (cnt_q != 2'd0) ? skid_q[head_q] : in_instr;
  assign cnt_nxt   = cnt_q + 2'(push) - 2'(pop);
  assign in_ready  = in_ready_q;

  // Skid occupancy and registered ready; flush empties both entries.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q  <= 2'd0;
      head_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      head_q <= head_q ^ pop;
    end
    if (rst) in_ready_q <= 1'b0;
    else     in_ready_q <= (state_nxt == RUN) && (flush || (cnt_nxt < 2'd2));
  end

  // Skid storage: write at tail (head + count).
  always_ff @(posedge clk) begin
    if (push) skid_q[head_q ^ cnt_q[0]] <= in_instr;
  end
`else
  assign in_ready  = (state == RUN) && out_adv;
  assign load_out  = accept;
  assign src_instr = in_instr;
`endif

  ctrl_lut #(
    .OPC_W  (OPC_W),
    .ALUOP_W(ALUOP_W)
  ) u_ctrl_lut (
    .opcode(src_instr[INSTR_W-1 -: OPC_W]),
    .funct (src_instr[ALUOP_W-1:0]),
    .ctrl  (dec_ctrl),
    .alu_op(dec_alu_op)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: flush wins over start; an illegal accept halts unless flushed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!flush && start) state_nxt = RUN;
      RUN:     if (accept && !flush && !in_legal) state_nxt = HALT;
      HALT:    if (flush) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: registered control bundle ----
  // Output register: load on transfer, hold while stalled, drop on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      alu_op_p1 <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
      imm_p1    <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load_out) begin
      vld_p1    <= 1'b1;
      ctrl_p1   <= dec_ctrl;
      alu_op_p1 <= dec_alu_op;
      rs_p1     <= src_instr[RS_HI -: REG_AW];
      rt_p1     <= src_instr[RT_HI -: REG_AW];
      rd_p1     <= src_instr[RD_HI -: REG_AW];
      imm_p1    <= sext_imm(src_instr[IMM_W-1:0]);
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid    = vld_p1;
  assign branch       = ctrl_p1.branch;
  assign mem_read     = ctrl_p1.mem_read;
  assign mem_to_reg   = ctrl_p1.mem_to_reg;
  assign mem_write    = ctrl_p1.mem_write;
  assign alu_src      = ctrl_p1.alu_src;
  assign reg_write    = ctrl_p1.reg_write;
  assign ra_reg_write = ctrl_p1.ra_reg_write;
  assign illegal      = ctrl_p1.illegal;
  assign alu_op       = alu_op_p1;
  assign rs           = rs_p1;
  assign rt           = rt_p1;
  assign rd           = rd_p1;
  assign imm_ext      = imm_p1;
  assign halted       = (state == HALT);

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus a
// randomized valid/ready stream scored against a table-driven decode model.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst, start, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, ra_reg_write;
  logic        illegal, halted;
  logic [3:0]  alu_op;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .ra_reg_write(ra_reg_write), .alu_op(alu_op), .rs(rs), .rt(rt), .rd(rd),
    .imm_ext(imm_ext), .illegal(illegal), .halted(halted)
  );

  typedef struct packed {
    logic br, mr, m2r, mw, as, rw, ra, ill;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
  } bnd_t;

  // Reference decode straight from the opcode table.
  function automatic bnd_t ref_decode(input logic [31:0] w);
    bnd_t b;
    b     = '0;
    b.rs  = w[25:21];
    b.rt  = w[20:16];
    b.rd  = w[15:11];
    b.imm = {{16{w[15]}}, w[15:0]};
    case (w[31:26])
      6'd0: begin b.rw = 1; b.op = w[3:0]; end
      6'd1: begin b.as = 1; b.rw = 1; end
      6'd2: begin b.mr = 1; b.m2r = 1; b.as = 1; b.rw = 1; end
      6'd3: begin b.mw = 1; b.as = 1; end
      6'd4: begin b.br = 1; end
      6'd5: begin b.br = 1; b.ra = 1; end
      default: b.ill = 1;
    endcase
    return b;
  endfunction

  function automatic bnd_t dut_bnd();
    return {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, ra_reg_write,
            illegal, alu_op, rs, rt, rd, imm_ext};
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'($urandom_range(0, 5));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; flush = 0; in_valid = 0; in_instr = '0; out_ready = 1;
    repeat (2) tick();
    rst = 0; in_valid = 1; in_instr = 32'h0AA00004;
    @(negedge clk);
    n_cmp++; if (dut_bnd() !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h want 0", dut_bnd()); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", in_ready); end
      tick();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
    end
    in_valid = 0;
  endtask

  task automatic test_decode();
    logic [31:0] w   [5];
    logic [31:0] imm [5];
    w   = '{32'h0AA00004, 32'h02B5A805, 32'h0C228000, 32'h0461FFFE, 32'h10000123};
    imm = '{32'h00000004, 32'hFFFFA805, 32'hFFFF8000, 32'hFFFFFFFE, 32'h00000123};
    tick();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_instr = w[i];
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dec_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      in_valid = 0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dec_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (dut_bnd() !== ref_decode(w[i])) begin n_fail++; $display("FAIL dec_bundle[%0d]: got %h want %h", i, dut_bnd(), ref_decode(w[i])); end
      n_cmp++; if (imm_ext !== imm[i]) begin n_fail++; $display("FAIL dec_imm[%0d]: got %h want %h", i, imm_ext, imm[i]); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if ({alu_op, rd} !== {4'h0, 5'd0}) begin n_fail++; $display("FAIL br_fields: got %h want 0", {alu_op, rd}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = rand_legal();
    out_ready = 1;
    for (int i = 0; i <= 4; i++) begin
      in_valid = (i < 4);
      in_instr = (i < 4) ? w[i] : '0;
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
        n_cmp++; if (dut_bnd() !== ref_decode(w[i-1])) begin n_fail++; $display("FAIL b2b_bundle[%0d]: got %h want %h", i, dut_bnd(), ref_decode(w[i-1])); end
      end
      if (i < 4) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      end
      tick();
    end
    in_valid = 0;
  endtask

  task automatic test_stall();
    logic [31:0] w [8];
    bnd_t        q [$];
    bnd_t        held_b;
    logic        held;
    logic        saw_block;
    int          sent, got;
    for (int i = 0; i < 8; i++) w[i] = rand_legal();
    sent = 0; got = 0; held = 0; held_b = '0; saw_block = 0;
    for (int c = 0; c < 40 && !(sent == 8 && q.size() == 0); c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (sent < 8);
      in_instr  = (sent < 8) ? w[sent] : '0;
      @(negedge clk);
      if (held) begin
        n_cmp++; if (out_valid !== 1'b1 || dut_bnd() !== held_b) begin n_fail++; $display("FAIL stall_hold: got %b/%h want 1/%h", out_valid, dut_bnd(), held_b); end
      end
`ifndef DECODE_SKID_EN
      n_cmp++; if (in_ready !== (!out_valid || out_ready)) begin n_fail++; $display("FAIL stall_ready: got %b want %b", in_ready, !out_valid || out_ready); end
`endif
      if (in_valid && !in_ready) saw_block = 1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin n_fail++; $display("FAIL stall_extra: got %h want none", dut_bnd()); end
        else begin
          bnd_t e;
          e = q.pop_front();
          got++;
          if (dut_bnd() !== e) begin n_fail++; $display("FAIL stall_bundle: got %h want %h", dut_bnd(), e); end
        end
      end
      held   = out_valid && !out_ready;
      held_b = dut_bnd();
      if (in_valid && in_ready) begin q.push_back(ref_decode(in_instr)); sent++; end
      tick();
    end
    in_valid = 0; out_ready = 1;
    n_cmp++; if (got !== 8 || q.size() !== 0) begin n_fail++; $display("FAIL stall_drain: got %0d delivered want 8", got); end
    n_cmp++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL stall_backpressure: got %b want 1", saw_block); end
  endtask

  task automatic test_random();
    bnd_t q [$];
    int   sent, got;
    sent = 0; got = 0;
    for (int c = 0; c < 260; c++) begin
      in_valid  = (c < 240) && ($urandom_range(0, 9) < 7);
      in_instr  = rand_legal();
      out_ready = (c >= 240) || ($urandom_range(0, 9) < 6);
      @(negedge clk);
`ifndef DECODE_SKID_EN
      n_cmp++; if (in_ready !== (!out_valid || out_ready)) begin n_fail++; $display("FAIL rnd_ready: got %b want %b", in_ready, !out_valid || out_ready); end
`endif
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rnd_extra: got %h want none", dut_bnd()); end
        else begin
          bnd_t e;
          e = q.pop_front();
          got++;
          if (dut_bnd() !== e) begin n_fail++; $display("FAIL rnd_bundle: got %h want %h", dut_bnd(), e); end
        end
      end
      if (in_valid && in_ready) begin q.push_back(ref_decode(in_instr)); sent++; end
      tick();
    end
    in_valid = 0; out_ready = 1;
    n_cmp++; if (got !== sent || q.size() !== 0) begin n_fail++; $display("FAIL rnd_drain: got %0d want %0d", got, sent); end
  endtask

  task automatic test_illegal();
    out_ready = 1;
    in_valid = 1; in_instr = 32'hFC001234;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready: got %b want 1", in_ready); end
    tick();
    in_instr = 32'h04220007;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || dut_bnd() !== ref_decode(32'hFC001234)) begin n_fail++; $display("FAIL ill_bundle: got %b/%h want 1/%h", out_valid, dut_bnd(), ref_decode(32'hFC001234)); end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ill_halted: got %b want 1", halted); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
      start = (i == 1);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid[%0d]: got %b want 0", i, out_valid); end
    end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_start_ignored: got %b want 1", halted); end
    in_valid = 0; start = 0; flush = 1;
    tick();
    flush = 0;
    @(negedge clk);
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL flush_unhalt: got %b want 0", halted); end
    in_valid = 1; in_instr = 32'h04220007;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL resume_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || dut_bnd() !== ref_decode(32'h04220007)) begin n_fail++; $display("FAIL resume_bundle: got %b/%h want 1/%h", out_valid, dut_bnd(), ref_decode(32'h04220007)); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1;
    in_valid = 1; in_instr = 32'h14000010;
    tick();
    in_instr = 32'h04210033; flush = 1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || {branch, ra_reg_write, reg_write} !== 3'b110) begin n_fail++; $display("FAIL call_ctrl: got %b/%b want 1/110", out_valid, {branch, ra_reg_write, reg_write}); end
    n_cmp++; if (dut_bnd() !== ref_decode(32'h14000010)) begin n_fail++; $display("FAIL call_bundle: got %h want %h", dut_bnd(), ref_decode(32'h14000010)); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_acc_ready: got %b want 1", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop[%0d]: got %b want 0", i, out_valid); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL flush_run: got %b want 0", halted); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    in_valid = 1; in_instr = 32'h08430010;
    tick();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %b want 1", out_valid); end
    rst = 1;
    tick();
    rst = 0; in_valid = 1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || dut_bnd() !== '0) begin n_fail++; $display("FAIL mid_reset: got %b/%h want 0/0", out_valid, dut_bnd()); end
    n_cmp++; if (in_ready !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %b%b want 00", in_ready, halted); end
    out_ready = 1;
    tick();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_nostart: got %b%b want 00", out_valid, in_ready); end
    in_valid = 0; start = 1;
    tick();
    start = 0; in_valid = 1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_restart_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || dut_bnd() !== ref_decode(32'h08430010)) begin n_fail++; $display("FAIL mid_restart: got %b/%h want 1/%h", out_valid, dut_bnd(), ref_decode(32'h08430010)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_stall();
    test_random();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered instruction-decode pipeline stage for the KGPRISC core; successor to the single-cycle combinational decoder.
- Takes fetched instruction words on a valid/ready handshake and produces one registered control bundle per instruction: branch, memory, ALU and register-write controls, register indices and sign-extended immediate.
- Adds start gating, flush, and a halt-on-illegal-opcode state machine. Sits between fetch and execute.

Parameters:
- INSTR_W, 32: instruction width.
- OPC_W, 6: opcode field width, at [INSTR_W-1 -: OPC_W].
- REG_AW, 5: register index width; rs, rt and rd follow the opcode in that order (for defaults rs=[25:21], rt=[20:16], rd=[15:11]).
- IMM_W, 16: immediate field width, at [IMM_W-1:0].
- ALUOP_W, 4: ALU operation code width. For R-type, alu_op = instr[ALUOP_W-1:0] (funct).
- DATA_W, 32: width of the sign-extended immediate output.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that enables decoding
- flush  in  1  discard the held output and leave HALT
- in_valid  in  1  instruction presented
- in_instr  in  INSTR_W  instruction word
- in_ready  out  1  stage accepts the instruction this cycle
- out_valid  out  1  control bundle valid
- out_ready  in  1  downstream accepts the bundle
- branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, ra_reg_write  out  1 each  control signals
- alu_op  out  ALUOP_W  ALU operation
- rs, rt, rd  out  REG_AW each  register indices
- imm_ext  out  DATA_W  sign-extended immediate
- illegal  out  1  bundle carries an undefined opcode
- halted  out  1  FSM is in HALT

Behaviour:
- Reset: synchronous, active-high, on clk. FSM goes to IDLE. All outputs 0 (out_valid, every control bit, alu_op, rs, rt, rd, imm_ext, illegal, halted). Reset mid-transfer drops the held bundle.
- FSM states:
  - IDLE: in_ready=0. start → RUN.
  - RUN: normal decoding.
  - HALT: halted=1, in_ready=0. flush → RUN. start is ignored.
- Handshake and latency:
  - Accept when in_valid && in_ready.
  - Registered bundle appears the next cycle with out_valid=1. Latency 1.
  - The bundle holds stable while out_valid && !out_ready.
  - In RUN, in_ready = !out_valid || out_ready. Back-to-back issue gives throughput 1/cycle.
- Decode table (opcode → controls). Unlisted control bits are 0.
  - 000000 R-type: reg_write=1, alu_op=funct.
  - 000001 ADDI: alu_src=1, reg_write=1, alu_op=0.
  - 000010 LW: mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=0.
  - 000011 SW: mem_write=1, alu_src=1, alu_op=0.
  - 000100 BR: branch=1.
  - 000101 CALL: branch=1, ra_reg_write=1.
  - Any other opcode: all controls 0, illegal=1. The bundle is still emitted, and the FSM enters HALT on the accept edge.
- Field rules: imm_ext = sign extension of instr[IMM_W-1:0] to DATA_W. rs, rt and rd are passed through for every opcode.
- flush: clears out_valid the next cycle. It overrides a same-cycle accept, and that instruction is dropped. From HALT the FSM returns to RUN.
- rst has priority over flush. flush has priority over start.
- An illegal instruction accepted while out_ready stalls is still held until consumed.

Optional Feature:
- DECODE_SKID_EN defined: a 2-entry skid buffer sits in front of the output register, and in_ready is a registered signal, high while fewer than 2 entries are held. Throughput stays 1/cycle. flush and rst empty both entries.
- Not defined: in_ready is the combinational expression given under Behaviour, and there is no extra storage.

Decomposition:
- Package kgprisc_pkg holds the opcode localparams (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BR, OP_CALL), the FSM state encoding (IDLE, RUN, HALT) and a packed control-bundle struct/typedef.
- Sub-module ctrl_lut is natural: a purely combinational opcode/funct → control bundle lookup, which the stage registers.

Test Plan:
- Reset then instruction 0x0AA00004 with no start: in_ready=0 and out_valid stays 0. After start, the same instruction in_valid=1 → next cycle mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, rs=21, rt=0, imm_ext=0x00000004.
- R-type 0x02B5A805 accepted → reg_write=1, alu_src=0, alu_op=4'h5, rs=21, rt=21, rd=21. Next, SW with imm 0x8000 → mem_write=1, imm_ext=0xFFFF8000.
- Four back-to-back instructions with out_ready=1 → four bundles on consecutive cycles. Then out_ready=0 for 3 cycles → bundle stable and in_ready=0 (in_ready=1 until full under DECODE_SKID_EN). Release → no loss or duplication.
- Opcode 0x3F accepted → illegal=1, all controls 0, halted=1, in_ready=0. Further in_valid is ignored. flush → halted=0, and decoding resumes the next accept.
- CALL 0x14000010 → branch=1, ra_reg_write=1, reg_write=0. A flush in the same cycle as a new accept → out_valid=0 next cycle and the instruction is dropped.
- rst asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, FSM in IDLE, and start is required again.
